// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the 1011 overlapping sequence detector.
// Accepts WIDTH-bit words on valid/ready and shifts them out on x, one bit per clock.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned   CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             handshake;

  assign in_ready  = !abort && ((state_q == StIdle) || (cnt_q == '0));
  assign handshake = in_valid && in_ready;
  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = (state_q == StShift);
  assign word_done = x_valid_q && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    if (abort) begin
      state_d   = StIdle;
      cnt_d     = '0;
      x_d       = IDLE_BIT;
      x_valid_d = 1'b0;
    end else if (handshake) begin
      // shreg keeps only the bits still to be sent, aligned at the output end
      x_d       = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
      shreg_d   = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
      cnt_d     = CntLast;
      x_valid_d = 1'b1;
      state_d   = StShift;
    end else if (state_q == StShift) begin
      if (cnt_q != '0) begin
        x_d     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_d   = cnt_q - CntOne;
      end else begin
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        state_d   = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      x_q       <= IDLE_BIT;
      x_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first instance plus an LSB-first instance.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid, abort;
  logic       in_ready, x, x_valid, busy, word_done;

  logic [7:0] l_data;
  logic       l_valid, l_abort;
  logic       l_ready, l_x, l_x_valid, l_busy, l_word_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .abort    (abort),
    .x        (x),
    .x_valid  (x_valid),
    .busy     (busy),
    .word_done(word_done)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (l_data),
    .in_valid (l_valid),
    .in_ready (l_ready),
    .abort    (l_abort),
    .x        (l_x),
    .x_valid  (l_x_valid),
    .busy     (l_busy),
    .word_done(l_word_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the 8 MSB-first bits of word on the primary instance, advancing one clock per bit.
  task automatic expect_word(input string tag, input logic [7:0] word);
    logic [7:0] w;
    w = word;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_x"}, x, w[7-i]);
      check({tag, "_xv"}, x_valid, 1'b1);
      check({tag, "_done"}, word_done, (i == 7));
      tick();
    end
  endtask

  initial begin
    logic [3:0] hist;
    int         zcnt;
    logic [15:0] stream;
    logic [7:0]  lw;

    reset_n = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0;
    l_data = '0; l_valid = 1'b0; l_abort = 1'b0;

    // 1: reset
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check("rst_x", x, 1'b0);
    check("rst_xv", x_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_done", word_done, 1'b0);
    tick();

    // 2: single word B0, detector model sees 1011 once at bit 3
    in_data = 8'hB0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hist = '0; zcnt = 0;
    for (int i = 0; i < 8; i++) begin
      check("w1_x", x, (i == 0 || i == 2 || i == 3));
      check("w1_xv", x_valid, 1'b1);
      check("w1_busy", busy, 1'b1);
      check("w1_done", word_done, (i == 7));
      hist = {hist[2:0], x};
      if (hist == 4'b1011) begin
        zcnt++;
        check("w1_zpos", i, 3);
      end
      tick();
    end
    check("w1_zcnt", zcnt, 1);
    check("w1_end_xv", x_valid, 1'b0);
    check("w1_end_x", x, 1'b0);
    check("w1_end_busy", busy, 1'b0);
    check("w1_end_done", word_done, 1'b0);

    // 3: back-to-back B0 then 0B with in_valid held
    stream = 16'hB00B;
    in_data = 8'hB0; in_valid = 1'b1;
    tick();
    in_data = 8'h0B;
    for (int i = 0; i < 16; i++) begin
      check("b2b_x", x, stream[15-i]);
      check("b2b_xv", x_valid, 1'b1);
      check("b2b_done", word_done, (i == 7 || i == 15));
      check("b2b_ready", in_ready, (i == 7 || i == 15));
      tick();
      if (i == 7) in_valid = 1'b0;
    end
    check("b2b_end_xv", x_valid, 1'b0);

    // 4: abort on 3rd bit of FF, with a competing offer that must not be taken
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("ab_pre_x", x, 1'b1);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    #1;
    check("ab_ready_lo", in_ready, 1'b0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check("ab_x", x, 1'b0);
    check("ab_xv", x_valid, 1'b0);
    check("ab_done", word_done, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_ready_hi", in_ready, 1'b1);
    tick();
    check("ab_idle_xv", x_valid, 1'b0);

    // 5: async reset on the 4th bit, then a fresh word from its first bit
    in_data = 8'hB0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("ar_pre_xv", x_valid, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_x", x, 1'b0);
    check("ar_xv", x_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_done", word_done, 1'b0);
    reset_n = 1'b1;
    tick();
    check("ar_post_xv", x_valid, 1'b0);
    in_data = 8'h0B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_word("ar_w", 8'h0B);
    check("ar_end_xv", x_valid, 1'b0);

    // 6: LSB-first 0D; offer during the word while not ready is ignored
    lw = 8'h0D;
    l_data = lw; l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_x", l_x, lw[i]);
      check("lsb_xv", l_x_valid, 1'b1);
      check("lsb_done", l_word_done, (i == 7));
      if (i == 2) begin
        l_data = 8'hFF; l_valid = 1'b1;
        #1;
        check("lsb_ready_lo", l_ready, 1'b0);
      end
      if (i == 5) l_valid = 1'b0;
      tick();
    end
    check("lsb_end_xv", l_x_valid, 1'b0);
    check("lsb_end_busy", l_busy, 1'b0);
    check("lsb_main_idle", x_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
